// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier signal bundle for mult_arbiter
//
// Requester side : Req0/Req1 with operands A0/B0, A1/B1; Ack0/Ack1, Err, Product, Busy back.
// Multiplier side: MultSt, MultA, MultB out to the unit; MultIdle, MultDone, MultP back.
// slave  modport : the arbiter's view.
// master modport : the environment (requesters plus multiplier) view.
interface mult_arbiter_if #(
  parameter int WIDTH = 4
);
  logic                 Req0;
  logic                 Req1;
  logic [WIDTH-1:0]     A0;
  logic [WIDTH-1:0]     B0;
  logic [WIDTH-1:0]     A1;
  logic [WIDTH-1:0]     B1;
  logic                 Ack0;
  logic                 Ack1;
  logic                 Err;
  logic [2*WIDTH-1:0]   Product;
  logic                 Busy;
  logic                 MultSt;
  logic [WIDTH-1:0]     MultA;
  logic [WIDTH-1:0]     MultB;
  logic                 MultIdle;
  logic                 MultDone;
  logic [2*WIDTH-1:0]   MultP;

  modport slave (
    input  Req0, Req1, A0, B0, A1, B1, MultIdle, MultDone, MultP,
    output Ack0, Ack1, Err, Product, Busy, MultSt, MultA, MultB
  );

  modport master (
    output Req0, Req1, A0, B0, A1, B1, MultIdle, MultDone, MultP,
    input  Ack0, Ack1, Err, Product, Busy, MultSt, MultA, MultB
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one shift-add multiplier between two requesters
//
// Clk : clock, rising edge
// Rst : synchronous active-high reset
// bus : mult_arbiter_if.slave
//       requests/operands in, Ack0/Ack1/Err/Product/Busy out,
//       MultSt/MultA/MultB to the multiplier, MultIdle/MultDone/MultP from it.
// A grant registers the winner's operands, pulses start (held until the multiplier
// is idle), waits up to TMO cycles for done, then acknowledges for one cycle.
module mult_arbiter #(
  parameter int WIDTH = 4,
  parameter int TMO   = 64
) (
  input  logic          Clk,
  input  logic          Rst,
  mult_arbiter_if.slave bus
);
  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               grant;
  logic               last;
  logic               err_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic               req_any;
  logic               pick;
  logic               timeout;

  // Next state and all outputs; outputs depend only on registered state.
  always_comb begin
    state_nxt   = state;
    req_any     = bus.Req0 | bus.Req1;
    // On a tie the side that was not served last wins.
    pick        = (bus.Req0 & bus.Req1) ? ~last : bus.Req1;
    timeout     = (cnt == CW'(TMO - 1));
    bus.Ack0    = 1'b0;
    bus.Ack1    = 1'b0;
    bus.Err     = 1'b0;
    bus.Busy    = (state != IDLE);
    bus.MultSt  = 1'b0;
    bus.MultA   = mult_a;
    bus.MultB   = mult_b;
    bus.Product = product_q;
    case (state)
      IDLE: begin
        if (req_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Start stays high until the multiplier can take it (e.g. after our own reset).
        bus.MultSt = 1'b1;
        if (bus.MultIdle) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.MultDone || timeout) state_nxt = DONE;
      end
      DONE: begin
        bus.Ack0  = ~grant;
        bus.Ack1  = grant;
        bus.Err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      grant     <= 1'b0;
      last      <= 1'b1;
      err_q     <= 1'b0;
      cnt       <= '0;
      product_q <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant  <= pick;
            last   <= pick;
            cnt    <= '0;
            err_q  <= 1'b0;
            mult_a <= pick ? bus.A1 : bus.A0;
            mult_b <= pick ? bus.B1 : bus.B0;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // Done takes priority over a timeout in the same cycle.
          if (bus.MultDone) begin
            product_q <= bus.MultP;
            err_q     <= 1'b0;
          end else if (timeout) begin
            product_q <= '0;
            err_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter
module tb_mult_arbiter;
  localparam int WIDTH = 4;
  localparam int TMO   = 64;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mult_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mult_arbiter #(.WIDTH(WIDTH), .TMO(TMO)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Multiplier model: done with the product exactly 8 cycles after accepting start.
  logic       mul_busy = 1'b0;
  int         mul_cnt  = 0;
  logic [3:0] mul_a    = '0;
  logic [3:0] mul_b    = '0;
  logic       mul_done = 1'b0;
  logic [7:0] mul_p    = '0;
  bit         never_done = 1'b0;
  bit         force_busy = 1'b0;

  assign bus.MultIdle = ~mul_busy & ~force_busy;
  assign bus.MultDone = mul_done;
  assign bus.MultP    = mul_p;

  always @(posedge Clk) begin
    if (mul_busy) begin
      mul_cnt <= mul_cnt + 1;
      if (mul_cnt == 7) begin
        mul_done <= ~never_done;
        mul_p    <= {4'b0, mul_a} * {4'b0, mul_b};
      end else if (mul_cnt == 8) begin
        mul_done <= 1'b0;
        mul_busy <= 1'b0;
      end
    end else if (bus.MultSt && bus.MultIdle) begin
      mul_busy <= 1'b1;
      mul_cnt  <= 1;
      mul_a    <= bus.MultA;
      mul_b    <= bus.MultB;
    end
  end

  typedef struct {
    bit         rst;
    bit         r0;
    bit         r1;
    logic [3:0] a0, b0, a1, b1;
    bit         g;
    logic [7:0] p1;
    logic [7:0] p2;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    tick();
    Rst = 1'b0;
  endtask

  task automatic wait_ack(output int n, output bit which, output logic [7:0] p, output bit e,
                          output int st, output logic [3:0] ca, output logic [3:0] cb);
    n = -1; which = 1'b0; p = '0; e = 1'b0; st = 0; ca = '0; cb = '0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (bus.MultSt) begin
        st++;
        ca = bus.MultA;
        cb = bus.MultB;
      end
      if (bus.Ack0 || bus.Ack1) begin
        n = i;
        which = bus.Ack1;
        p = bus.Product;
        e = bus.Err;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  // Transaction-level reference model state for the random phase.
  int         m_t;
  bit         m_g, m_last;
  logic [3:0] m_a, m_b;
  logic [7:0] m_prod;

  initial begin
    int n, st, wcnt;
    bit w, e, exp_side, dropped0, dropped1;
    logic [7:0] p;
    logic [3:0] ca, cb;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 4'd13, 4'd11, 4'd0,  4'd0,  1'b0, 8'd143, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 4'd3,  4'd5,  4'd15, 4'd15, 1'b0, 8'd15,  8'd225};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd3,  4'd5,  4'd15, 4'd15, 1'b0, 8'd15,  8'd225};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'd0,  4'd7,  1'b1, 8'd0,   8'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'd15, 4'd1,  4'd2,  4'd2,  1'b0, 8'd15,  8'd4};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'd15, 4'd15, 1'b1, 8'd225, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 8'd0,   8'd0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd1,  4'd1,  4'd6,  4'd7,  1'b1, 8'd42,  8'd1};

    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    tick();
    tick();
    check("rst_busy", bus.Busy, 0);
    check("rst_ack0", bus.Ack0, 0);
    check("rst_ack1", bus.Ack1, 0);
    check("rst_err", bus.Err, 0);
    check("rst_product", bus.Product, 0);
    check("rst_multst", bus.MultSt, 0);
    check("rst_multa", bus.MultA, 0);
    check("rst_multb", bus.MultB, 0);
    Rst = 1'b0;

    // Table-driven grants
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      bus.A0 = vecs[i].a0; bus.B0 = vecs[i].b0;
      bus.A1 = vecs[i].a1; bus.B1 = vecs[i].b1;
      bus.Req0 = vecs[i].r0; bus.Req1 = vecs[i].r1;
      wait_ack(n, w, p, e, st, ca, cb);
      check($sformatf("v%0d_grant", i), w, vecs[i].g);
      check($sformatf("v%0d_product", i), p, vecs[i].p1);
      check($sformatf("v%0d_err", i), e, 0);
      check($sformatf("v%0d_latency", i), n, 10);
      check($sformatf("v%0d_st_cycles", i), st, 1);
      check($sformatf("v%0d_multa", i), ca, vecs[i].g ? vecs[i].a1 : vecs[i].a0);
      check($sformatf("v%0d_multb", i), cb, vecs[i].g ? vecs[i].b1 : vecs[i].b0);
      if (w) bus.Req1 = 1'b0; else bus.Req0 = 1'b0;
      if (vecs[i].r0 && vecs[i].r1) begin
        wait_ack(n, w, p, e, st, ca, cb);
        check($sformatf("v%0d_grant2", i), w, !vecs[i].g);
        check($sformatf("v%0d_product2", i), p, vecs[i].p2);
        check($sformatf("v%0d_latency2", i), n, 11);
        if (w) bus.Req1 = 1'b0; else bus.Req0 = 1'b0;
      end
      tick();
    end

    // Starvation: Req1 held, Req0 re-requests right after every Ack0
    do_reset();
    bus.A0 = 4'd2; bus.B0 = 4'd3; bus.A1 = 4'd4; bus.B1 = 4'd5;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    exp_side = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(n, w, p, e, st, ca, cb);
      check($sformatf("alt%0d_grant", k), w, exp_side);
      check($sformatf("alt%0d_product", k), p, exp_side ? 20 : 6);
      if (!w) begin
        bus.Req0 = 1'b0;
        tick();
        bus.Req0 = 1'b1;
      end
      exp_side = !exp_side;
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    tick();
    tick();

    // Timeout: multiplier never signals done
    never_done = 1'b1;
    bus.A0 = 4'd5; bus.B0 = 4'd5; bus.Req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MultSt) break;
    end
    wcnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      wcnt++;
      if (bus.Ack0 || bus.Ack1) break;
    end
    check("tmo_wait_cycles", wcnt - 1, TMO);
    check("tmo_ack0", bus.Ack0, 1);
    check("tmo_err", bus.Err, 1);
    check("tmo_product", bus.Product, 0);
    bus.Req0 = 1'b0;
    tick();
    check("tmo_err_one_cycle", bus.Err, 0);
    check("tmo_idle", bus.Busy, 0);
    never_done = 1'b0;
    bus.A1 = 4'd6; bus.B1 = 4'd6; bus.Req1 = 1'b1;
    wait_ack(n, w, p, e, st, ca, cb);
    check("post_tmo_grant", w, 1);
    check("post_tmo_product", p, 36);
    check("post_tmo_err", e, 0);
    bus.Req1 = 1'b0;
    tick();

    // Busy multiplier: MultIdle low for 5 cycles after grant
    force_busy = 1'b1;
    bus.A0 = 4'd7; bus.B0 = 4'd9; bus.Req0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("busy_st%0d", i), bus.MultSt, 1);
      tick();
    end
    force_busy = 1'b0;
    check("busy_st_release", bus.MultSt, 1);
    tick();
    check("busy_st_drop", bus.MultSt, 0);
    check("busy_in_wait", bus.Busy, 1);
    wait_ack(n, w, p, e, st, ca, cb);
    check("busy_latency", n, 8);
    check("busy_product", p, 63);
    check("busy_err", e, 0);
    bus.Req0 = 1'b0;
    tick();

    // Reset while in WAIT, then an immediate request that must wait for the multiplier
    bus.A0 = 4'd9; bus.B0 = 4'd9; bus.Req0 = 1'b1;
    tick();
    tick();
    tick();
    tick();
    Rst = 1'b1;
    bus.Req0 = 1'b0;
    tick();
    check("rw_busy", bus.Busy, 0);
    check("rw_ack0", bus.Ack0, 0);
    check("rw_ack1", bus.Ack1, 0);
    check("rw_err", bus.Err, 0);
    check("rw_multst", bus.MultSt, 0);
    check("rw_product", bus.Product, 0);
    check("rw_multa", bus.MultA, 0);
    check("rw_multb", bus.MultB, 0);
    Rst = 1'b0;
    bus.A1 = 4'd10; bus.B1 = 4'd12; bus.Req1 = 1'b1;
    wait_ack(n, w, p, e, st, ca, cb);
    check("rw_next_grant", w, 1);
    check("rw_next_product", p, 120);
    check("rw_next_err", e, 0);
    check("rw_st_held", (st >= 2), 1);
    bus.Req1 = 1'b0;
    tick();

    // Random traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    m_t = 0; m_g = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_prod = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      // grant edge -> 1 issue cycle, 8 wait cycles, 1 ack cycle, then idle for one edge
      if (m_t == 10) begin
        m_t = 0;
      end else if (m_t > 0) begin
        m_t++;
        if (m_t == 10) m_prod = {4'b0, m_a} * {4'b0, m_b};
      end else if (bus.Req0 || bus.Req1) begin
        m_g    = (bus.Req0 && bus.Req1) ? !m_last : bus.Req1;
        m_last = m_g;
        m_a    = m_g ? bus.A1 : bus.A0;
        m_b    = m_g ? bus.B1 : bus.B0;
        m_t    = 1;
      end
      check("rnd_busy", bus.Busy, m_t != 0);
      check("rnd_ack0", bus.Ack0, (m_t == 10) && !m_g);
      check("rnd_ack1", bus.Ack1, (m_t == 10) && m_g);
      check("rnd_err", bus.Err, 0);
      check("rnd_multst", bus.MultSt, m_t == 1);
      check("rnd_product", bus.Product, m_prod);
      if (m_t != 0) begin
        check("rnd_multa", bus.MultA, m_a);
        check("rnd_multb", bus.MultB, m_b);
      end
      dropped0 = 1'b0;
      dropped1 = 1'b0;
      if (m_t == 10) begin
        if (m_g) begin bus.Req1 = 1'b0; dropped1 = 1'b1; end
        else     begin bus.Req0 = 1'b0; dropped0 = 1'b1; end
      end
      if (!bus.Req0 && !dropped0 && $urandom_range(0, 2) == 0) begin
        bus.A0 = 4'($urandom_range(0, 15));
        bus.B0 = 4'($urandom_range(0, 15));
        bus.Req0 = 1'b1;
      end
      if (!bus.Req1 && !dropped1 && $urandom_range(0, 2) == 0) begin
        bus.A1 = 4'($urandom_range(0, 15));
        bus.B1 = 4'($urandom_range(0, 15));
        bus.Req1 = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
